// File: rtl/oled_arb_pkg.sv
// Shared types and constants for the OLED update arbiter.
// Holds the refresh FSM state encoding, field widths, ASCII constants
// and the nibble-to-hex-digit helper used by hex-format writes.
package oled_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int PAGE_W = 2;
  localparam int COL_W  = 4;
  localparam int CHAR_W = 8;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_M10 = 8'h37;

  // Convert a 4-bit value to its upper-case ASCII hex digit.
  function automatic logic [7:0] hex_nib_to_ascii(input logic [3:0] nib);
    logic [7:0] base;
    base = (nib < 4'd10) ? ASCII_0 : ASCII_A_M10;
    return base + {4'd0, nib};
  endfunction

endpackage

// File: rtl/oled_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the
// pointer, wrapping modulo N_REQ. Purely combinational.
module oled_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  int  pos;
  logic hit;

  // Scan requesters starting from the pointer; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    pos = 0;
    hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      pos      = int'(ptr) + k;
      pos      = (pos >= N_REQ) ? (pos - N_REQ) : pos;
      hit      = !vld && req[pos];
      gnt[pos] = gnt[pos] | hit;
      idx      = hit ? IDX_W'(pos) : idx;
      vld      = vld | hit;
    end
  end

endmodule

// File: rtl/oled_update_arbiter.sv
// OLED text-buffer arbiter: round-robin char writes into a 4x16 buffer,
// snapshots the buffer and runs the controller EN/FIN handshake with a
// FIN timeout and a minimum idle gap between refreshes.
// Optional feature macro: OLED_HEX_FMT_EN (hex-digit pair writes).
module oled_update_arbiter
  import oled_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int GAP_CYC     = 1000,
  parameter int TIMEOUT_CYC = 16777216
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N_REQ-1:0]      req,
  input  logic [2*N_REQ-1:0]    req_page,
  input  logic [4*N_REQ-1:0]    req_col,
  input  logic [8*N_REQ-1:0]    req_char,
  input  logic [N_REQ-1:0]      req_hex,
  output logic [N_REQ-1:0]      gnt,
  output logic                  oled_en,
  input  logic                  oled_fin,
  output logic [127:0]          page0,
  output logic [127:0]          page1,
  output logic [127:0]          page2,
  output logic [127:0]          page3,
  output logic                  busy,
  output logic                  err_tmo
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAXC  = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  gnt_idx;
  logic              accept;
  logic [PAGE_W-1:0] wr_page;
  logic [COL_W-1:0]  wr_col;
  logic [COL_W-1:0]  wr_col_nx;
  logic [CHAR_W-1:0] wr_char;
  logic [6:0]        wr_lsb;
  logic [6:0]        wr_lsb_nx;
  logic              wr_hex;
  logic              unused_hex;

  logic [127:0]      text_buf [4];
  logic              dirty;
  logic              snap;
  state_t            state;
  logic [CNT_W-1:0]  cnt;

  oled_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .vld (accept)
  );

  // Column c occupies bits [127-8c -: 8]; ~c*8 is its LSB for a 4-bit column.
  assign wr_page    = req_page[gnt_idx*PAGE_W +: PAGE_W];
  assign wr_col     = req_col[gnt_idx*COL_W +: COL_W];
  assign wr_char    = req_char[gnt_idx*CHAR_W +: CHAR_W];
  assign wr_hex     = req_hex[gnt_idx];
  assign wr_col_nx  = wr_col + 4'd1;
  assign wr_lsb     = {~wr_col, 3'b000};
  assign wr_lsb_nx  = {~wr_col_nx, 3'b000};
  assign unused_hex = wr_hex;

  assign snap = (state == S_IDLE) && dirty;
  assign busy = (state != S_IDLE);

  // Advance the round-robin pointer past each granted requester.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Buffer writes: one accepted request per cycle, independent of refresh state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int p = 0; p < 4; p++) text_buf[p] <= '0;
    end else if (accept) begin
`ifdef OLED_HEX_FMT_EN
      if (wr_hex) begin
        text_buf[wr_page][wr_lsb +: 8] <= hex_nib_to_ascii(wr_char[7:4]);
        if (wr_col != 4'd15) begin
          text_buf[wr_page][wr_lsb_nx +: 8] <= hex_nib_to_ascii(wr_char[3:0]);
        end
      end else begin
        text_buf[wr_page][wr_lsb +: 8] <= wr_char;
      end
`else
      text_buf[wr_page][wr_lsb +: 8] <= wr_char;
`endif
    end
  end

  // Dirty flag: a new write wins over the snapshot that clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dirty <= 1'b0;
    end else if (accept) begin
      dirty <= 1'b1;
    end else if (snap) begin
      dirty <= 1'b0;
    end
  end

  // Refresh FSM: snapshot + EN, wait for FIN or timeout, then enforce idle gap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      cnt     <= '0;
      oled_en <= 1'b0;
      err_tmo <= 1'b0;
      page0   <= '0;
      page1   <= '0;
      page2   <= '0;
      page3   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dirty) begin
            page0   <= text_buf[0];
            page1   <= text_buf[1];
            page2   <= text_buf[2];
            page3   <= text_buf[3];
            oled_en <= 1'b1;
            cnt     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (oled_fin) begin
            oled_en <= 1'b0;
            cnt     <= '0;
            state   <= S_GAP;
          end else if (cnt == TMO_LAST) begin
            oled_en <= 1'b0;
            err_tmo <= 1'b1;
            cnt     <= '0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          oled_en <= 1'b0;
          cnt     <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_update_arbiter.sv
// Directed self-checking bench for oled_update_arbiter (N_REQ=4, GAP_CYC=8,
// TIMEOUT_CYC=64). Inputs change 1 time unit after the rising edge; outputs
// are sampled well before the next rising edge.
module tb_oled_update_arbiter;

  localparam int N   = 4;
  localparam int GAP = 8;
  localparam int TMO = 64;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_page;
  logic [4*N-1:0] req_col;
  logic [8*N-1:0] req_char;
  logic [N-1:0]   req_hex;
  logic [N-1:0]   gnt;
  logic           oled_en;
  logic           oled_fin;
  logic [127:0]   page0, page1, page2, page3;
  logic           busy;
  logic           err_tmo;

  int tests = 0;
  int fails = 0;

  oled_update_arbiter #(.N_REQ(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .req_page(req_page), .req_col(req_col),
    .req_char(req_char), .req_hex(req_hex), .gnt(gnt), .oled_en(oled_en),
    .oled_fin(oled_fin), .page0(page0), .page1(page1), .page2(page2),
    .page3(page3), .busy(busy), .err_tmo(err_tmo)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    req = '0; req_page = '0; req_col = '0; req_char = '0; req_hex = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] p, input logic [3:0] c,
                         input logic [7:0] ch, input logic hx);
    req[i] = 1'b1;
    req_page[2*i +: 2] = p;
    req_col[4*i +: 4]  = c;
    req_char[8*i +: 8] = ch;
    req_hex[i] = hx;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    oled_fin = 1'b0;
    clear_req();
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    oled_fin = 1'b0;
    clear_req();
    #2;
    tests++; if (oled_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b expected 0", oled_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (err_tmo !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_tmo); end
    tests++; if ((page0 | page1 | page2 | page3) !== 128'd0) begin fails++; $display("FAIL reset_pages: got nonzero expected 0"); end
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    tick();
    RST_N = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'd3, 4'd15, 8'h2E, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = 4'b0001 << (k % 4);
      tests++; if (gnt !== exp) begin fails++; $display("FAIL rr_all_cycle%0d: got %b expected %b", k, gnt, exp); end
      tick();
    end
    clear_req();
    set_req(2, 2'd0, 4'd0, 8'h20, 1'b0);
    #1;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL rr_single_ptr0: got %b expected 0100", gnt); end
    tick();
    #1;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL rr_single_ptr3: got %b expected 0100", gnt); end
    clear_req();
    set_req(1, 2'd0, 4'd0, 8'h20, 1'b0);
    set_req(3, 2'd0, 4'd0, 8'h20, 1'b0);
    #1;
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL rr_1010_ptr3: got %b expected 1000", gnt); end
    tick();
    #1;
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL rr_1010_ptr0: got %b expected 0010", gnt); end
    clear_req();
    #1;
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rr_none: got %b expected 0000", gnt); end
  endtask

  task automatic test_write_refresh();
    int en_seen;
    do_reset();
    set_req(1, 2'd1, 4'd0, 8'h41, 1'b0);
    tick();
    clear_req();
    tests++; if (oled_en !== 1'b0) begin fails++; $display("FAIL wr_en_early: got %b expected 0", oled_en); end
    tick();
    tests++; if (oled_en !== 1'b1) begin fails++; $display("FAIL wr_en_rise: got %b expected 1", oled_en); end
    tests++; if (page1[127:120] !== 8'h41) begin fails++; $display("FAIL wr_page1_col0: got %h expected 41", page1[127:120]); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_run: got %b expected 1", busy); end
    tick(); tick(); tick();
    set_req(0, 2'd0, 4'd5, 8'h5A, 1'b0);
    tick();
    clear_req();
    tests++; if (page0 !== 128'd0) begin fails++; $display("FAIL wr_frozen_page0: got %h expected 0", page0); end
    tests++; if (oled_en !== 1'b1) begin fails++; $display("FAIL wr_en_held: got %b expected 1", oled_en); end
    oled_fin = 1'b1;
    tick();
    oled_fin = 1'b0;
    tests++; if (oled_en !== 1'b0) begin fails++; $display("FAIL wr_en_drop: got %b expected 0", oled_en); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_gap: got %b expected 1", busy); end
    en_seen = 0;
    for (int g = 1; g <= GAP; g++) begin
      oled_fin = (g == 3) ? 1'b1 : 1'b0;
      tick();
      if (oled_en === 1'b1) en_seen++;
    end
    oled_fin = 1'b0;
    tests++; if (en_seen != 0) begin fails++; $display("FAIL wr_gap_en_low: got %0d high cycles expected 0", en_seen); end
    tick();
    tests++; if (oled_en !== 1'b1) begin fails++; $display("FAIL wr_second_refresh: got %b expected 1", oled_en); end
    tests++; if (page0[87:80] !== 8'h5A) begin fails++; $display("FAIL wr_page0_col5: got %h expected 5a", page0[87:80]); end
    tests++; if (page1[127:120] !== 8'h41) begin fails++; $display("FAIL wr_page1_kept: got %h expected 41", page1[127:120]); end
    oled_fin = 1'b1;
    tick();
    oled_fin = 1'b0;
    for (int g = 0; g < GAP + 3; g++) tick();
    tests++; if (oled_en !== 1'b0) begin fails++; $display("FAIL wr_no_third: got %b expected 0", oled_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_req(2, 2'd2, 4'd1, 8'h41, 1'b0);
    tick();
    clear_req();
    set_req(2, 2'd2, 4'd2, 8'h42, 1'b0);
    tick();
    clear_req();
    tests++; if (page2[119:112] !== 8'h41) begin fails++; $display("FAIL sim_col1: got %h expected 41", page2[119:112]); end
    tests++; if (page2[111:104] !== 8'h00) begin fails++; $display("FAIL sim_col2_pre: got %h expected 00", page2[111:104]); end
    oled_fin = 1'b1;
    tick();
    oled_fin = 1'b0;
    for (int g = 0; g < GAP; g++) tick();
    tick();
    tests++; if (oled_en !== 1'b1) begin fails++; $display("FAIL sim_refresh2: got %b expected 1", oled_en); end
    tests++; if (page2[111:104] !== 8'h42) begin fails++; $display("FAIL sim_col2_post: got %h expected 42", page2[111:104]); end
  endtask

  task automatic test_timeout_and_async_reset();
    do_reset();
    set_req(0, 2'd0, 4'd0, 8'h31, 1'b0);
    tick();
    clear_req();
    tick();
    tests++; if (oled_en !== 1'b1) begin fails++; $display("FAIL tmo_en_rise: got %b expected 1", oled_en); end
    set_req(3, 2'd3, 4'd7, 8'h37, 1'b0);
    tick();
    clear_req();
    for (int k = 0; k < TMO - 2; k++) tick();
    tests++; if (oled_en !== 1'b1 || err_tmo !== 1'b0) begin fails++; $display("FAIL tmo_before: got en=%b err=%b expected en=1 err=0", oled_en, err_tmo); end
    tick();
    tests++; if (oled_en !== 1'b0) begin fails++; $display("FAIL tmo_en_fall: got %b expected 0", oled_en); end
    tests++; if (err_tmo !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b expected 1", err_tmo); end
    for (int g = 0; g < GAP; g++) tick();
    tests++; if (oled_en !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL tmo_gap_end: got en=%b busy=%b expected 0 0", oled_en, busy); end
    tick();
    tests++; if (oled_en !== 1'b1) begin fails++; $display("FAIL tmo_resume: got %b expected 1", oled_en); end
    tests++; if (page3[71:64] !== 8'h37 || err_tmo !== 1'b1) begin fails++; $display("FAIL tmo_resume_data: got %h err=%b expected 37 err=1", page3[71:64], err_tmo); end
    #3;
    RST_N = 1'b0;
    #1;
    tests++; if (oled_en !== 1'b0) begin fails++; $display("FAIL areset_en: got %b expected 0", oled_en); end
    tests++; if ((page0 | page1 | page2 | page3) !== 128'd0) begin fails++; $display("FAIL areset_pages: got nonzero expected 0"); end
    tests++; if (err_tmo !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL areset_flags: got err=%b busy=%b expected 0 0", err_tmo, busy); end
    tick();
    RST_N = 1'b1;
  endtask

  task automatic test_hex_mode();
    logic [7:0] exp2, exp3, exp15;
`ifdef OLED_HEX_FMT_EN
    exp2 = 8'h33; exp3 = 8'h43; exp15 = 8'h33;
`else
    exp2 = 8'h3C; exp3 = 8'h00; exp15 = 8'h3C;
`endif
    do_reset();
    set_req(1, 2'd0, 4'd2, 8'h3C, 1'b1);
    tick();
    clear_req();
    tick();
    tests++; if (page0[111:104] !== exp2) begin fails++; $display("FAIL hex_col2: got %h expected %h", page0[111:104], exp2); end
    tests++; if (page0[103:96] !== exp3) begin fails++; $display("FAIL hex_col3: got %h expected %h", page0[103:96], exp3); end
    do_reset();
    set_req(1, 2'd0, 4'd15, 8'h3C, 1'b1);
    tick();
    clear_req();
    tick();
    tests++; if (page0[7:0] !== exp15) begin fails++; $display("FAIL hex_col15: got %h expected %h", page0[7:0], exp15); end
    tests++; if (page0[127:8] !== 120'd0) begin fails++; $display("FAIL hex_col15_nowrap: got %h expected 0", page0[127:8]); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_refresh();
    test_simultaneous();
    test_timeout_and_async_reset();
    test_hex_mode();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
